// File: rtl/disp_rx_cfg_pkg.sv
// Shared configuration for the display timing receiver: geometry width,
// saturation limit, FSM encoding and the measured-geometry record.
package disp_rx_cfg;
  localparam int GEO_W = 12;
  localparam logic [GEO_W-1:0] SAT_MAX = 12'hFFF;

  typedef enum logic [1:0] {S_IDLE, S_MEAS, S_LOCKED} rx_state_t;

  typedef struct packed {
    logic [GEO_W-1:0] h_tot;
    logic [GEO_W-1:0] h_act;
    logic [GEO_W-1:0] v_tot;
    logic [GEO_W-1:0] v_act;
  } geo_t;

  function automatic logic [GEO_W-1:0] sat_inc(input logic [GEO_W-1:0] v);
    return (v == SAT_MAX) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// Registers one video control input, normalises it to active-high and
// produces a single-cycle pulse on the selected edge of the registered level.
module sync_edge_det #(
  parameter bit INVERT = 1'b0,
  parameter bit FALL   = 1'b0
) (
  input  logic ClkDisp,
  input  logic Rst_p,
  input  logic din,
  output logic lvl,
  output logic pulse
);
  logic prev;

  always_ff @(posedge ClkDisp or posedge Rst_p) begin
    if (Rst_p) begin
      lvl  <= 1'b0;
      prev <= 1'b0;
    end else begin
      lvl  <= din ^ INVERT;
      prev <= lvl;
    end
  end

  assign pulse = FALL ? (prev & ~lvl) : (lvl & ~prev);
endmodule

// File: rtl/disp_timing_rx.sv
// Video timing receiver: recovers pixel coordinates, measures line/frame
// geometry, and declares lock once the geometry repeats for LOCK_FRAMES frames.
module disp_timing_rx
  import disp_rx_cfg::*;
#(
  parameter int DATA_W           = 24,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic              ClkDisp,
  input  logic              Rst_p,
  input  logic              Vin_HS,
  input  logic              Vin_VS,
  input  logic              Vin_DE,
  input  logic [DATA_W-1:0] Vin_Data,
  output logic              Pix_Valid,
  output logic [DATA_W-1:0] Pix_Data,
  output logic [GEO_W-1:0]  Pix_X,
  output logic [GEO_W-1:0]  Pix_Y,
  output logic              Frame_Begin,
  output logic [GEO_W-1:0]  H_Total,
  output logic [GEO_W-1:0]  H_Active,
  output logic [GEO_W-1:0]  V_Total,
  output logic [GEO_W-1:0]  V_Active,
  output logic              Locked,
  output logic              Timing_Err
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic hs_edge, vs_edge, de, de_fall, unused_hs_lvl, unused_vs_lvl;

  sync_edge_det #(.INVERT(!SYNC_ACTIVE_HIGH), .FALL(1'b0)) u_hs (
    .ClkDisp(ClkDisp), .Rst_p(Rst_p), .din(Vin_HS), .lvl(unused_hs_lvl), .pulse(hs_edge));
  sync_edge_det #(.INVERT(!SYNC_ACTIVE_HIGH), .FALL(1'b0)) u_vs (
    .ClkDisp(ClkDisp), .Rst_p(Rst_p), .din(Vin_VS), .lvl(unused_vs_lvl), .pulse(vs_edge));
  sync_edge_det #(.INVERT(1'b0), .FALL(1'b1)) u_de (
    .ClkDisp(ClkDisp), .Rst_p(Rst_p), .din(Vin_DE), .lvl(de), .pulse(de_fall));

  logic [DATA_W-1:0] data_r;
  logic [GEO_W-1:0]  xcnt, ycnt, hcnt, decnt, vcnt, vact, line_len, act_w;
  logic [GEO_W-1:0]  line_len_n, act_w_n, vcnt_n, vact_n;
  logic              h_bad, h_bad_n, cand_ok, hsat, lock_load;
  geo_t              cand, ref_geo;
  rx_state_t         state, state_n;
  logic [3:0]        match_cnt, match_n;

  always_ff @(posedge ClkDisp or posedge Rst_p) begin
    if (Rst_p) begin
      data_r      <= '0;
      xcnt        <= '0;
      ycnt        <= '0;
      Pix_Valid   <= 1'b0;
      Pix_Data    <= '0;
      Pix_X       <= '0;
      Pix_Y       <= '0;
      Frame_Begin <= 1'b0;
    end else begin
      data_r      <= Vin_Data;
      Pix_Valid   <= de;
      Pix_Data    <= de ? data_r : '0;
      Frame_Begin <= vs_edge;
      if (de) begin
        Pix_X <= xcnt;
        Pix_Y <= ycnt;
      end
      if (de_fall)  xcnt <= '0;
      else if (de)  xcnt <= sat_inc(xcnt);
      if (vs_edge)      ycnt <= '0;
      else if (de_fall) ycnt <= sat_inc(ycnt);
    end
  end

  // Line-close results are folded in before the frame snapshot, so an HS
  // coincident with VS still counts toward the closing frame.
  always_comb begin
    line_len_n = hs_edge ? sat_inc(hcnt) : line_len;
    vcnt_n     = hs_edge ? sat_inc(vcnt) : vcnt;
    act_w_n    = de_fall ? decnt : act_w;
    vact_n     = de_fall ? sat_inc(vact) : vact;
    h_bad_n    = h_bad | (de_fall && (vact != '0) && (decnt != act_w));
    cand       = {line_len_n, act_w_n, vcnt_n, vact_n};
    cand_ok    = !h_bad_n && (cand.h_tot != SAT_MAX) && (cand.h_act != SAT_MAX) &&
                 (cand.v_tot != SAT_MAX) && (cand.v_act != SAT_MAX);
    hsat       = (hcnt == SAT_MAX) && !hs_edge;
  end

  always_ff @(posedge ClkDisp or posedge Rst_p) begin
    if (Rst_p) begin
      hcnt     <= '0;
      decnt    <= '0;
      line_len <= '0;
      act_w    <= '0;
      vcnt     <= '0;
      vact     <= '0;
      h_bad    <= 1'b0;
    end else begin
      hcnt     <= hs_edge ? '0 : sat_inc(hcnt);
      decnt    <= de_fall ? '0 : (de ? sat_inc(decnt) : decnt);
      line_len <= line_len_n;
      act_w    <= act_w_n;
      if (vs_edge) begin
        vcnt  <= '0;
        vact  <= '0;
        h_bad <= 1'b0;
      end else begin
        vcnt  <= vcnt_n;
        vact  <= vact_n;
        h_bad <= h_bad_n;
      end
    end
  end

  always_comb begin
    state_n   = state;
    match_n   = match_cnt;
    lock_load = 1'b0;
    case (state)
      S_IDLE: if (vs_edge) begin
        state_n = S_MEAS;
        match_n = '0;
      end
      S_MEAS: if (vs_edge) begin
        if (!cand_ok)               match_n = '0;
        else if (cand == ref_geo)   match_n = (match_cnt == 4'hF) ? match_cnt : match_cnt + 4'd1;
        else                        match_n = 4'd1;
        if (match_n >= LOCK_N) begin
          state_n   = S_LOCKED;
          lock_load = 1'b1;
        end
      end
      S_LOCKED: if (vs_edge && (!cand_ok || cand != ref_geo)) begin
        state_n = S_MEAS;
        match_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
    // A missing HS overrides everything: geometry is meaningless without it.
    if (hsat) begin
      state_n   = S_IDLE;
      match_n   = '0;
      lock_load = 1'b0;
    end
  end

  always_ff @(posedge ClkDisp or posedge Rst_p) begin
    if (Rst_p) begin
      state      <= S_IDLE;
      match_cnt  <= '0;
      ref_geo    <= '0;
      Locked     <= 1'b0;
      Timing_Err <= 1'b0;
      H_Total    <= '0;
      H_Active   <= '0;
      V_Total    <= '0;
      V_Active   <= '0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      Locked     <= (state_n == S_LOCKED);
      Timing_Err <= (state == S_LOCKED) && (state_n != S_LOCKED);
      // Leaving IDLE starts from an empty reference so stale geometry never matches.
      if (vs_edge) ref_geo <= (state == S_IDLE) ? '0 : cand;
      if (lock_load) begin
        H_Total  <= cand.h_tot;
        H_Active <= cand.h_act;
        V_Total  <= cand.v_tot;
        V_Active <= cand.v_act;
      end
    end
  end
endmodule
